spi_cmd_sequencer: RTL and testbench
====================================

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: RAM data width; equals SPI byte width.
REQ-003 SHALL have port SCK, input, 1: sole clock; all state updates on posedge SCK.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port SSB, input, 1: SPI slave select, active-low frame enable.
REQ-006 SHALL have port rx_byte, input, 8: byte from slave shift register, valid only when rx_valid=1.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe, one per 8 SCK of a frame.
REQ-008 SHALL have port tx_byte, output, 8: byte for the shift register to transmit next.
REQ-009 SHALL have port tx_load, output, 1: one-cycle strobe; shift register loads tx_byte.
REQ-010 SHALL have port ram_addr, output, ADDR_W: RAM address, driven from address register AR.
REQ-011 SHALL have port ram_wdata, output, DATA_W: RAM write data.
REQ-012 SHALL have port ram_we, output, 1: one-cycle RAM write strobe.
REQ-013 SHALL have port ram_re, output, 1: one-cycle RAM read strobe; ram_rdata valid next cycle.
REQ-014 SHALL have port ram_rdata, input, DATA_W: RAM read data.
REQ-015 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL decode command from rx_byte[3:0] of the first rx_valid after SSB falls: 0x1 LOAD_AR, 0x2 WRITE, 0x3 READ, 0x5 RDSR; all others illegal.
REQ-017 SHALL implement states IDLE, CMD, ADDR, WR, RD_FETCH, RD_STREAM, STAT, IGNORE.
REQ-018 IDLE -> CMD when SSB=0; stays IDLE while SSB=1.
REQ-019 CMD on rx_valid: LOAD_AR -> ADDR, WRITE -> WR, READ -> RD_FETCH, RDSR -> STAT, illegal -> IGNORE and set STATUS[2].
REQ-020 ADDR: next rx_valid SHALL write AR <= rx_byte[ADDR_W-1:0], then -> IGNORE; further bytes in frame discarded.
REQ-021 WR: each rx_valid SHALL give ram_we=1, ram_wdata=rx_byte, ram_addr=AR the next cycle, then AR <= AR+1 (burst).
REQ-022 RD_FETCH: ram_re=1 at AR one cycle after entry; next cycle tx_byte<=ram_rdata, tx_load=1, AR<=AR+1, -> RD_STREAM.
REQ-023 RD_STREAM: each rx_valid (dummy byte) SHALL return to RD_FETCH, prefetching the next byte.
REQ-024 STAT: one cycle after entry, tx_byte<=STATUS, tx_load=1; STATUS[2:1] clear the same cycle; stays in STAT until SSB=1.
REQ-025 STATUS SHALL be 8 bits: [0] busy, [1] sticky AR wrap (AR incremented from all-ones to 0), [2] sticky illegal command, [7:3] zero.
REQ-026 AR increment SHALL be modulo 2^ADDR_W; wrap sets STATUS[1].
REQ-027 SSB=1 in any non-IDLE state SHALL force IDLE next cycle, suppressing any ram_we, ram_re or tx_load pending for that cycle; AR and STATUS retained.
REQ-028 rx_valid while SSB=1 SHALL be ignored.
REQ-029 ram_we and ram_re SHALL never be high in the same cycle; each strobe one cycle wide.
REQ-030 tx_byte SHALL hold its value between tx_load strobes.

Reset
REQ-031 reset=1 SHALL force state IDLE, AR=0, STATUS=0, tx_byte=0, tx_load=0, ram_we=0, ram_re=0, ram_wdata=0, busy=0 on the next posedge, overriding SSB and rx_valid; reset mid-frame aborts without a RAM strobe.

Verification
REQ-032 Frame 0x01,0x10 then frame 0x02,0xAA,0xBB -> ram_we twice: addr 0x10 data 0xAA, addr 0x11 data 0xBB; AR=0x12 at end.
REQ-033 AR=0x10, RAM[0x10]=0x5A, RAM[0x11]=0xC3; frame 0x03,dummy,dummy -> tx_load with 0x5A then 0xC3; AR=0x12.
REQ-034 LOAD_AR 0xFF, WRITE 0x77 -> RAM[0xFF]=0x77, AR=0x00; RDSR -> tx_byte=0x03 (busy+wrap); second RDSR -> 0x01.
REQ-035 Frame 0x0F,0x11 -> no RAM strobe, AR unchanged; RDSR -> 0x05.
REQ-036 SSB raised the cycle rx_valid of a WRITE data byte arrives -> no ram_we; state IDLE next cycle, busy=0.
REQ-037 reset pulsed during RD_FETCH -> no tx_load, AR=0, STATUS=0, state IDLE.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: command sequencer behind an SPI slave shift register.
// It decodes a command byte per frame and then loads the RAM address
// register, bursts writes, streams reads, or returns the status byte.
//
// Handshake: rx_valid is a one-cycle strobe that qualifies rx_byte and is
// honoured only while SSB=0. tx_load, ram_we and ram_re are registered
// one-cycle strobes. ram_rdata is taken one cycle after the ram_re cycle.
// tx_byte holds its value between tx_load strobes.
module spi_cmd_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              SCK,
  input  logic              reset,
  input  logic              SSB,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CMD       = 3'd1,
    S_ADDR      = 3'd2,
    S_WR        = 3'd3,
    S_RD_FETCH  = 3'd4,
    S_RD_STREAM = 3'd5,
    S_STAT      = 3'd6,
    S_IGNORE    = 3'd7
  } state_t;

  state_t            state, state_n;
  // Cycles spent in the current state, saturating at 3. RD_FETCH uses it
  // for the issue/wait/capture steps. STAT uses it to send only once.
  logic [1:0]        ph, ph_n;

  logic [ADDR_W-1:0] ar;
  logic              st_wrap;
  logic              st_illegal;
  logic [7:0]        status_byte;

  logic              we_n, re_n, load_n;
  logic [7:0]        tx_n;
  logic [DATA_W-1:0] wdata_n;
  logic              ar_load, rd_inc, ar_inc, stat_clr, ill_set;

  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;
  assign ram_addr    = ar;
  assign status_byte = {5'b00000, st_illegal, st_wrap, busy};
  // A committed write advances AR in its own strobe cycle, so the burst
  // continues even if the frame closes in that same cycle.
  assign ar_inc      = ram_we | rd_inc;

  // State register and in-state cycle counter
  always_ff @(posedge SCK) begin
    if (reset) begin
      state <= S_IDLE;
      ph    <= 2'd0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
    end
  end

  // Next-state logic. A closed frame always wins and returns to IDLE.
  always_comb begin
    state_n = state;
    if (state != S_IDLE && SSB) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (!SSB) state_n = S_CMD;
        S_CMD: begin
          if (rx_valid) begin
            case (rx_byte[3:0])
              4'h1:    state_n = S_ADDR;
              4'h2:    state_n = S_WR;
              4'h3:    state_n = S_RD_FETCH;
              4'h5:    state_n = S_STAT;
              default: state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR:      if (rx_valid) state_n = S_IGNORE;
        S_WR:        state_n = S_WR;
        S_RD_FETCH:  if (ph == 2'd2) state_n = S_RD_STREAM;
        S_RD_STREAM: if (rx_valid) state_n = S_RD_FETCH;
        S_STAT:      state_n = S_STAT;
        S_IGNORE:    state_n = S_IGNORE;
        default:     state_n = S_IDLE;
      endcase
    end
    if (state_n != state) ph_n = 2'd0;
    else if (ph != 2'd3)  ph_n = ph + 2'd1;
    else                  ph_n = ph;
  end

  // Output/datapath decisions. Nothing is issued while SSB=1.
  always_comb begin
    we_n     = 1'b0;
    re_n     = 1'b0;
    load_n   = 1'b0;
    tx_n     = tx_byte;
    wdata_n  = ram_wdata;
    ar_load  = 1'b0;
    rd_inc   = 1'b0;
    stat_clr = 1'b0;
    ill_set  = 1'b0;
    if (!SSB) begin
      case (state)
        S_CMD: begin
          if (rx_valid && rx_byte[3:0] != 4'h1 && rx_byte[3:0] != 4'h2 &&
              rx_byte[3:0] != 4'h3 && rx_byte[3:0] != 4'h5)
            ill_set = 1'b1;
        end
        S_ADDR: begin
          if (rx_valid) ar_load = 1'b1;
        end
        S_WR: begin
          if (rx_valid) begin
            we_n    = 1'b1;
            wdata_n = DATA_W'(rx_byte);
          end
        end
        S_RD_FETCH: begin
          if (ph == 2'd0) re_n = 1'b1;
          if (ph == 2'd2) begin
            tx_n   = 8'(ram_rdata);
            load_n = 1'b1;
            rd_inc = 1'b1;
          end
        end
        S_STAT: begin
          if (ph == 2'd0) begin
            tx_n     = status_byte;
            load_n   = 1'b1;
            stat_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered strobes, address register and sticky status bits
  always_ff @(posedge SCK) begin
    if (reset) begin
      ar         <= '0;
      st_wrap    <= 1'b0;
      st_illegal <= 1'b0;
      tx_byte    <= 8'h00;
      tx_load    <= 1'b0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      ram_we    <= we_n;
      ram_re    <= re_n;
      tx_load   <= load_n;
      tx_byte   <= tx_n;
      ram_wdata <= wdata_n;
      if (ar_load)     ar <= ADDR_W'(rx_byte);
      else if (ar_inc) ar <= ar + ADDR_W'(1);
      if (stat_clr) begin
        st_wrap    <= 1'b0;
        st_illegal <= 1'b0;
      end
      if (!ar_load && ar_inc && (&ar)) st_wrap <= 1'b1;
      if (ill_set) st_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: a synchronous RAM model, a monitor logging
// RAM writes and transmitted bytes, and a frame-level reference model.
module tb_spi_cmd_sequencer;

  localparam int LOG_N = 4096;

  logic       SCK = 1'b0;
  logic       reset, SSB, rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_load, ram_we, ram_re, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic [2:0] state_dbg;

  // clock / reset
  always #5 SCK = ~SCK;

  spi_cmd_sequencer #(.ADDR_W(8), .DATA_W(8)) dut (
    .SCK(SCK), .reset(reset), .SSB(SSB), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata), .busy(busy),
    .state_dbg(state_dbg)
  );

  // synchronous RAM, with a preload port owned by the bench
  logic [7:0] ram_mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;
  always @(posedge SCK) begin
    if (pre_we)      ram_mem[pre_addr] <= pre_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  // monitor: logs strobes and tracks strobe/hold rule violations
  logic [15:0] wr_log [LOG_N];
  logic [7:0]  tx_log [LOG_N];
  int          wr_n = 0, tx_n = 0, re_n = 0, strobe_err = 0, hold_err = 0;
  logic        we_d = 1'b0, re_d = 1'b0, rst_d = 1'b1;
  logic [7:0]  tx_prev = 8'h00;
  always @(negedge SCK) begin
    if (ram_we === 1'b1) begin wr_log[wr_n % LOG_N] = {ram_addr, ram_wdata}; wr_n++; end
    if (tx_load === 1'b1) begin tx_log[tx_n % LOG_N] = tx_byte; tx_n++; end
    if (ram_re === 1'b1) re_n++;
    if ((ram_we === 1'b1 && ram_re === 1'b1) || (ram_we === 1'b1 && we_d) ||
        (ram_re === 1'b1 && re_d)) strobe_err++;
    if (!rst_d && tx_load !== 1'b1 && tx_byte !== tx_prev) hold_err++;
    we_d = (ram_we === 1'b1); re_d = (ram_re === 1'b1); rst_d = (reset !== 1'b0);
    tx_prev = tx_byte;
  end

  // reference model state and scoreboard
  logic [7:0]  m_mem [256];
  logic [7:0]  m_ar;
  logic        m_wrap, m_ill;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  fb [8];
  int          wr_seen = 0, tx_seen = 0;
  int          n_checks = 0, n_errors = 0;

  task automatic tick();
    @(posedge SCK); #1;
  endtask

  task automatic sync_logs();
    wr_seen = wr_n;
    tx_seen = tx_n;
    exp_wr_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Frame-level model: what a frame of n bytes does, given that SSB rises
  // in the cycle right after the last byte's strobe.
  task automatic model_frame(input int n);
    case (fb[0][3:0])
      4'h1: if (n >= 2) m_ar = fb[1];
      4'h2: for (int i = 1; i < n; i++) begin
        exp_wr_q.push_back({m_ar, fb[i]});
        m_mem[m_ar] = fb[i];
        if (m_ar == 8'hFF) m_wrap = 1'b1;
        m_ar = m_ar + 8'd1;
      end
      4'h3: for (int i = 1; i < n; i++) begin
        exp_tx_q.push_back(m_mem[m_ar]);
        if (m_ar == 8'hFF) m_wrap = 1'b1;
        m_ar = m_ar + 8'd1;
      end
      4'h5: if (n >= 2) begin
        exp_tx_q.push_back({5'b00000, m_ill, m_wrap, 1'b1});
        m_ill = 1'b0;
        m_wrap = 1'b0;
      end
      default: m_ill = 1'b1;
    endcase
  endtask

  // driver: one byte every 8 SCK, rx_valid high for one cycle
  task automatic send_byte(input logic [7:0] b);
    repeat (7) tick();
    rx_byte = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_byte = 8'($urandom);
  endtask

  task automatic send_frame(input int n);
    SSB = 1'b0;
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    SSB = 1'b1;
    repeat (4) tick();
    model_frame(n);
  endtask

  task automatic test_reset();
    reset = 1'b1; SSB = 1'b0; rx_valid = 1'b1; rx_byte = 8'h12;
    repeat (3) tick();
    n_checks++; if (state_dbg !== 3'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (tx_load !== 1'b0) begin n_errors++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
    n_checks++; if (tx_byte !== 8'h00) begin n_errors++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    n_checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_errors++; $display("FAIL reset_ram_strobes got=%b%b exp=00", ram_we, ram_re); end
    n_checks++; if (ram_wdata !== 8'h00) begin n_errors++; $display("FAIL reset_wdata got=%h exp=00", ram_wdata); end
    n_checks++; if (ram_addr !== 8'h00) begin n_errors++; $display("FAIL reset_ar got=%h exp=00", ram_addr); end
    reset = 1'b0; SSB = 1'b1; rx_valid = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    m_ar = 8'h00; m_wrap = 1'b0; m_ill = 1'b0;
    sync_logs();
  endtask

  task automatic test_write_burst();
    fb[0] = 8'h01; fb[1] = 8'h10; send_frame(2);
    fb[0] = 8'h02; fb[1] = 8'hAA; fb[2] = 8'hBB; send_frame(3);
    n_checks++; if (wr_n - wr_seen != 2) begin n_errors++; $display("FAIL wr_count got=%0d exp=2", wr_n - wr_seen); end
    n_checks++; if (wr_log[wr_seen % LOG_N] !== 16'h10AA) begin n_errors++; $display("FAIL wr_first got=%h exp=10AA", wr_log[wr_seen % LOG_N]); end
    n_checks++; if (wr_log[(wr_seen + 1) % LOG_N] !== 16'h11BB) begin n_errors++; $display("FAIL wr_second got=%h exp=11BB", wr_log[(wr_seen + 1) % LOG_N]); end
    n_checks++; if (ram_addr !== 8'h12) begin n_errors++; $display("FAIL wr_ar got=%h exp=12", ram_addr); end
    n_checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL wr_idle got=%0d/%b exp=0/0", state_dbg, busy); end
    sync_logs();
  endtask

  task automatic test_read_stream();
    int re0;
    fb[0] = 8'h01; fb[1] = 8'h10; send_frame(2);
    preload(8'h10, 8'h5A);
    preload(8'h11, 8'hC3);
    sync_logs();
    re0 = re_n;
    fb[0] = 8'h03; fb[1] = 8'($urandom); fb[2] = 8'($urandom); send_frame(3);
    n_checks++; if (tx_n - tx_seen != 2) begin n_errors++; $display("FAIL rd_count got=%0d exp=2", tx_n - tx_seen); end
    n_checks++; if (tx_log[tx_seen % LOG_N] !== 8'h5A) begin n_errors++; $display("FAIL rd_first got=%h exp=5A", tx_log[tx_seen % LOG_N]); end
    n_checks++; if (tx_log[(tx_seen + 1) % LOG_N] !== 8'hC3) begin n_errors++; $display("FAIL rd_second got=%h exp=C3", tx_log[(tx_seen + 1) % LOG_N]); end
    n_checks++; if (ram_addr !== 8'h12) begin n_errors++; $display("FAIL rd_ar got=%h exp=12", ram_addr); end
    n_checks++; if (wr_n != wr_seen) begin n_errors++; $display("FAIL rd_no_write got=%0d exp=0", wr_n - wr_seen); end
    n_checks++; if (re_n - re0 < 2) begin n_errors++; $display("FAIL rd_re_count got=%0d exp>=2", re_n - re0); end
    sync_logs();
  endtask

  task automatic test_wrap_status();
    fb[0] = 8'h01; fb[1] = 8'hFF; send_frame(2);
    fb[0] = 8'h02; fb[1] = 8'h77; send_frame(2);
    n_checks++; if (ram_mem[8'hFF] !== 8'h77) begin n_errors++; $display("FAIL wrap_ram got=%h exp=77", ram_mem[8'hFF]); end
    n_checks++; if (ram_addr !== 8'h00) begin n_errors++; $display("FAIL wrap_ar got=%h exp=00", ram_addr); end
    fb[0] = 8'h05; fb[1] = 8'h00; send_frame(2);
    fb[0] = 8'h05; fb[1] = 8'h00; send_frame(2);
    n_checks++; if (tx_n - tx_seen != 2) begin n_errors++; $display("FAIL stat_count got=%0d exp=2", tx_n - tx_seen); end
    n_checks++; if (tx_log[tx_seen % LOG_N] !== 8'h03) begin n_errors++; $display("FAIL stat_wrap got=%h exp=03", tx_log[tx_seen % LOG_N]); end
    n_checks++; if (tx_log[(tx_seen + 1) % LOG_N] !== 8'h01) begin n_errors++; $display("FAIL stat_cleared got=%h exp=01", tx_log[(tx_seen + 1) % LOG_N]); end
    sync_logs();
  endtask

  task automatic test_illegal();
    int re0;
    re0 = re_n;
    fb[0] = 8'h0F; fb[1] = 8'h11; send_frame(2);
    n_checks++; if (wr_n != wr_seen || re_n != re0) begin n_errors++; $display("FAIL ill_no_strobe got=%0d/%0d exp=0/0", wr_n - wr_seen, re_n - re0); end
    n_checks++; if (ram_addr !== 8'h00) begin n_errors++; $display("FAIL ill_ar got=%h exp=00", ram_addr); end
    fb[0] = 8'h05; fb[1] = 8'h00; send_frame(2);
    n_checks++; if (tx_n - tx_seen != 1 || tx_log[tx_seen % LOG_N] !== 8'h05) begin n_errors++; $display("FAIL ill_status got=%h (n=%0d) exp=05", tx_log[tx_seen % LOG_N], tx_n - tx_seen); end
    sync_logs();
  endtask

  task automatic test_ssb_abort();
    fb[0] = 8'h01; fb[1] = 8'h40; send_frame(2);
    sync_logs();
    SSB = 1'b0;
    send_byte(8'h02);
    repeat (7) tick();
    rx_byte = 8'h99; rx_valid = 1'b1; SSB = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle got=%0d/%b exp=0/0", state_dbg, busy); end
    repeat (4) tick();
    n_checks++; if (wr_n != wr_seen) begin n_errors++; $display("FAIL abort_no_write got=%0d exp=0", wr_n - wr_seen); end
    n_checks++; if (ram_addr !== 8'h40) begin n_errors++; $display("FAIL abort_ar got=%h exp=40", ram_addr); end
    sync_logs();
  endtask

  task automatic test_reset_fetch();
    int re0;
    fb[0] = 8'h0A; fb[1] = 8'h00; send_frame(2);
    fb[0] = 8'h01; fb[1] = 8'h30; send_frame(2);
    sync_logs();
    re0 = re_n;
    SSB = 1'b0;
    send_byte(8'h03);
    reset = 1'b1; SSB = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL rstf_idle got=%0d/%b exp=0/0", state_dbg, busy); end
    n_checks++; if (ram_addr !== 8'h00) begin n_errors++; $display("FAIL rstf_ar got=%h exp=00", ram_addr); end
    repeat (4) tick();
    n_checks++; if (re_n != re0 || tx_n != tx_seen) begin n_errors++; $display("FAIL rstf_no_strobe got=%0d/%0d exp=0/0", re_n - re0, tx_n - tx_seen); end
    m_ar = 8'h00; m_wrap = 1'b0; m_ill = 1'b0;
    fb[0] = 8'h05; fb[1] = 8'h00; send_frame(2);
    n_checks++; if (tx_n - tx_seen != 1 || tx_log[tx_seen % LOG_N] !== 8'h01) begin n_errors++; $display("FAIL rstf_status got=%h (n=%0d) exp=01", tx_log[tx_seen % LOG_N], tx_n - tx_seen); end
    sync_logs();
  endtask

  task automatic test_random();
    logic [3:0]  nib;
    logic [15:0] ew;
    logic [7:0]  et;
    int          n;
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 5))
        0: nib = 4'h1;
        1: nib = 4'h2;
        2: nib = 4'h3;
        3: nib = 4'h5;
        4: begin
          nib = 4'($urandom_range(0, 15));
          while (nib == 4'h1 || nib == 4'h2 || nib == 4'h3 || nib == 4'h5)
            nib = 4'($urandom_range(0, 15));
        end
        default: nib = 4'h1;
      endcase
      n = $urandom_range(1, 5);
      fb[0] = {4'($urandom), nib};
      for (int i = 1; i < 8; i++) fb[i] = 8'($urandom);
      if (nib == 4'h1 && $urandom_range(0, 1) == 1) fb[1] = 8'hFC + 8'($urandom_range(0, 3));
      send_frame(n);
      while (exp_wr_q.size() > 0 && wr_seen < wr_n) begin
        ew = exp_wr_q.pop_front();
        n_checks++;
        if (wr_log[wr_seen % LOG_N] !== ew) begin n_errors++; $display("FAIL rnd_write f=%0d got=%h exp=%h", f, wr_log[wr_seen % LOG_N], ew); end
        wr_seen++;
      end
      n_checks++; if (exp_wr_q.size() != 0 || wr_seen != wr_n) begin n_errors++; $display("FAIL rnd_write_count f=%0d extra_got=%0d missing=%0d", f, wr_n - wr_seen, exp_wr_q.size()); end
      while (exp_tx_q.size() > 0 && tx_seen < tx_n) begin
        et = exp_tx_q.pop_front();
        n_checks++;
        if (tx_log[tx_seen % LOG_N] !== et) begin n_errors++; $display("FAIL rnd_tx f=%0d got=%h exp=%h", f, tx_log[tx_seen % LOG_N], et); end
        tx_seen++;
      end
      n_checks++; if (exp_tx_q.size() != 0 || tx_seen != tx_n) begin n_errors++; $display("FAIL rnd_tx_count f=%0d extra_got=%0d missing=%0d", f, tx_n - tx_seen, exp_tx_q.size()); end
      n_checks++; if (ram_addr !== m_ar) begin n_errors++; $display("FAIL rnd_ar f=%0d got=%h exp=%h", f, ram_addr, m_ar); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rnd_busy f=%0d got=%b exp=0", f, busy); end
      sync_logs();
    end
  endtask

  task automatic test_strobe_rules();
    n_checks++; if (strobe_err != 0) begin n_errors++; $display("FAIL strobe_rules got=%0d exp=0", strobe_err); end
    n_checks++; if (hold_err != 0) begin n_errors++; $display("FAIL tx_hold got=%0d exp=0", hold_err); end
  endtask

  initial begin
    reset = 1'b1; SSB = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    test_reset();
    test_write_burst();
    test_read_stream();
    test_wrap_status();
    test_illegal();
    test_ssb_abort();
    test_reset_fetch();
    test_random();
    test_strobe_rules();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // final report if the run overstays its cycle budget
  initial begin
    #400000;
    n_errors++;
    n_checks++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
